// File: rtl/cam_frame_source_pkg.sv
// rtl/cam_frame_source_pkg.sv - shared FSM encodings, pattern codes, bar colours and CRC helper
package cam_frame_source_pkg;

  // Frame-timing FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBP    = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_HBLANK = 3'd4;
  localparam logic [2:0] ST_VFP    = 3'd5;

  // pattern_sel codes
  localparam logic [1:0] PAT_SOLID = 2'b00;
  localparam logic [1:0] PAT_BARS  = 2'b01;
  localparam logic [1:0] PAT_ADDR  = 2'b10;
  localparam logic [1:0] PAT_GRAD  = 2'b11;

  // CRC-16/CCITT used for frame_crc
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Colour-bar palette, left to right
  function automatic logic [15:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    return 16'hFFFF; // white
      3'd1:    return 16'hFFE0; // yellow
      3'd2:    return 16'h07FF; // cyan
      3'd3:    return 16'h07E0; // green
      3'd4:    return 16'hF81F; // magenta
      3'd5:    return 16'hF800; // red
      3'd6:    return 16'h001F; // blue
      default: return 16'h0000; // black
    endcase
  endfunction

  // One byte of CRC-16/CCITT, MSB first
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/cam_frame_source_pattern_gen.sv
// rtl/cam_frame_source_pattern_gen.sv - combinational RGB565 test-pattern generator (cam_pattern_gen)
module cam_pattern_gen
  import cam_frame_source_pkg::*;
#(
  parameter int WIDTH = 176
) (
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [4:0]  frame_cnt,
  input  logic [15:0] solid,
  output logic [15:0] rgb565
);

  logic [2:0] bar;

  // Map pixel coordinates to a colour for the selected pattern
  always_comb begin
    bar    = 3'(({16'd0, x} << 3) / 32'(WIDTH));
    rgb565 = solid;
    case (pattern_sel)
      PAT_SOLID: rgb565 = solid;
      PAT_BARS:  rgb565 = bar_colour(bar);
      PAT_ADDR:  rgb565 = 16'(({16'd0, y} * 32'(WIDTH)) + {16'd0, x});
      default:   rgb565 = {x[4:0], y[5:0], frame_cnt};
    endcase
  end

endmodule

// File: rtl/cam_frame_source.sv
// rtl/cam_frame_source.sv - OV7670-style RGB565 frame transmitter; macro FRAME_CRC_EN adds frame_crc
module cam_frame_source
  import cam_frame_source_pkg::*;
#(
  parameter int WIDTH       = 176,
  parameter int HEIGHT      = 144,
  parameter int HBLANK      = 32,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb565,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
`ifdef FRAME_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam int ACT_LEN   = 2 * WIDTH;
  localparam int LINE_LEN  = ACT_LEN + HBLANK;
  localparam int VSYNC_LEN = VSYNC_LINES * LINE_LEN;
  localparam int VBP_LEN   = VBP_LINES * LINE_LEN;
  localparam int VFP_LEN   = VFP_LINES * LINE_LEN;
  localparam int MAX_V1    = (VSYNC_LEN > VBP_LEN) ? VSYNC_LEN : VBP_LEN;
  localparam int MAX_V2    = (MAX_V1 > VFP_LEN) ? MAX_V1 : VFP_LEN;
  localparam int MAX_LEN   = (MAX_V2 > LINE_LEN) ? MAX_V2 : LINE_LEN;
  localparam int CW        = $clog2(MAX_LEN + 1);
  localparam int YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_last;
  logic [YW-1:0] line_q, line_d;
  logic          pclk_q, pclk_d;
  logic          arm_q, arm_d;
  logic          done_q, done_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   solid_q, solid_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic [15:0]   pixel;
  logic          tick;
  logic          start;

  // A tick is the clk edge on which cam_pclk falls
  assign tick = pclk_q;

  // Length of the current FSM interval, in pclk periods, minus one
  always_comb begin
    case (state_q)
      ST_VSYNC:  cnt_last = CW'(VSYNC_LEN - 1);
      ST_VBP:    cnt_last = CW'(VBP_LEN - 1);
      ST_ACTIVE: cnt_last = CW'(ACT_LEN - 1);
      ST_HBLANK: cnt_last = CW'(HBLANK - 1);
      ST_VFP:    cnt_last = CW'(VFP_LEN - 1);
      default:   cnt_last = '0;
    endcase
  end

  // Frame sequencing; leaving IDLE first lets pclk rise once so vsync can rise on a tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    arm_d   = arm_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    start   = 1'b0;
    pclk_d  = ((state_q != ST_IDLE) || arm_q) ? ~pclk_q : 1'b0;
    if (state_q == ST_IDLE) begin
      if (!arm_q) begin
        arm_d = enable;
      end else if (tick) begin
        arm_d = 1'b0;
        start = 1'b1;
      end
    end else if (tick) begin
      if (cnt_q != cnt_last) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
        case (state_q)
          ST_VSYNC: state_d = ST_VBP;
          ST_VBP: begin
            state_d = ST_ACTIVE;
            line_d  = '0;
          end
          ST_ACTIVE: state_d = ST_HBLANK;
          ST_HBLANK: begin
            if (line_q != YW'(HEIGHT - 1)) begin
              line_d  = line_q + YW'(1);
              state_d = ST_ACTIVE;
            end else begin
              state_d = ST_VFP;
            end
          end
          default: begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
            if (enable) start = 1'b1;
            else        state_d = ST_IDLE;
          end
        endcase
      end
    end
    if (start) begin
      state_d = ST_VSYNC;
      cnt_d   = '0;
      line_d  = '0;
      pat_d   = pattern_sel;
      solid_d = solid_rgb565;
    end
  end

  // Timing and frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      pclk_q  <= 1'b0;
      arm_q   <= 1'b0;
      done_q  <= 1'b0;
      pat_q   <= '0;
      solid_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      pclk_q  <= pclk_d;
      arm_q   <= arm_d;
      done_q  <= done_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      fcnt_q  <= fcnt_d;
    end
  end

  cam_pattern_gen #(
    .WIDTH(WIDTH)
  ) u_pattern_gen (
    .pattern_sel(pat_q),
    .x          (16'(cnt_q >> 1)),
    .y          (16'(line_q)),
    .frame_cnt  (fcnt_q[4:0]),
    .solid      (solid_q),
    .rgb565     (pixel)
  );

  assign cam_pclk   = pclk_q;
  assign busy       = (state_q != ST_IDLE);
  assign cam_vsync  = (state_q == ST_VSYNC);
  assign cam_href   = (state_q == ST_ACTIVE);
  assign cam_data   = cam_href ? (cnt_q[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

`ifdef FRAME_CRC_EN
  logic [15:0] crc_acc_q, crc_acc_d;
  logic [15:0] frame_crc_q, frame_crc_d;
  logic        frame_end;

  assign frame_end = tick && (state_q == ST_VFP) && (cnt_q == cnt_last);

  // Fold each href byte into the running CRC; publish it alongside frame_done
  always_comb begin
    crc_acc_d   = crc_acc_q;
    frame_crc_d = frame_crc_q;
    if (tick && cam_href) crc_acc_d = crc16_ccitt_byte(crc_acc_q, cam_data);
    if (frame_end)        frame_crc_d = crc_acc_q;
    if (start)            crc_acc_d = CRC_INIT;
  end

  // CRC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_acc_q   <= '0;
      frame_crc_q <= '0;
    end else begin
      crc_acc_q   <= crc_acc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`endif

endmodule

// File: tb/tb_cam_frame_source.sv
// tb/tb_cam_frame_source.sv - self-checking bench for cam_frame_source with a frame-level model
module tb_cam_frame_source;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int L  = 2 * W + HB;

  localparam logic [15:0] BAR_RGB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [7:0] A_BYTES [16] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
                                          8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07};
  localparam logic [7:0] BAR_BYTES [8] = '{8'hFF, 8'hFF, 8'h07, 8'hFF, 8'hF8, 8'h1F, 8'h00, 8'h1F};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'b00;
  logic [15:0] solid_rgb565 = 16'h0000;
  logic        cam_pclk, cam_vsync, cam_href, busy, frame_done;
  logic [7:0]  cam_data;
  logic [15:0] frame_cnt;
`ifdef FRAME_CRC_EN
  logic [15:0] frame_crc;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cam_frame_source #(
    .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VSYNC_LINES(VS), .VBP_LINES(VB), .VFP_LINES(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb565(solid_rgb565), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
`ifdef FRAME_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  typedef struct packed {
    logic       bz;
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } ent_t;

  ent_t       exp_q[$];
  int         exp_fcnt = 0;
  bit         done_due = 0;
  bit         pclk_prev = 0;
  logic [7:0] rec_b[$];
  int         rec_vs = 0;
  int         pclk_since_vs = 0;
  int         done_at = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] model_pixel(input logic [1:0] pat, input int x, input int y,
                                              input int fc, input logic [15:0] solid);
    case (pat)
      2'b00:   return solid;
      2'b01:   return BAR_RGB[(x * 8) / W];
      2'b10:   return 16'((y * W + x) % 65536);
      default: return 16'(((x % 32) << 11) | ((y % 64) << 5) | (fc % 32));
    endcase
  endfunction

  // One entry per pclk period of a frame, as seen at the pclk rising edge
  task automatic push_frame(input bit from_idle);
    logic [15:0] px;
    if (from_idle) exp_q.push_back(ent_t'({1'b0, 1'b0, 1'b0, 8'h00}));
    repeat (VS * L) exp_q.push_back(ent_t'({1'b1, 1'b1, 1'b0, 8'h00}));
    repeat (VB * L) exp_q.push_back(ent_t'({1'b1, 1'b0, 1'b0, 8'h00}));
    for (int y = 0; y < H; y++) begin
      for (int b = 0; b < 2 * W; b++) begin
        px = model_pixel(pattern_sel, b / 2, y, exp_fcnt, solid_rgb565);
        exp_q.push_back(ent_t'({1'b1, 1'b0, 1'b1, (b % 2 == 1) ? px[7:0] : px[15:8]}));
      end
      repeat (HB) exp_q.push_back(ent_t'({1'b1, 1'b0, 1'b0, 8'h00}));
    end
    repeat (VF * L) exp_q.push_back(ent_t'({1'b1, 1'b0, 1'b0, 8'h00}));
  endtask

  // Compare process: every pclk rise against the model, frame_done on the following tick
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pclk_prev = 1'b0;
      end else begin
        if (cam_pclk && !pclk_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pclk", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("vsync", cam_vsync, e.vs);
            check("href", cam_href, e.hr);
            check("data", cam_data, e.d);
            check("busy", busy, e.bz);
            if (cam_vsync) rec_vs++;
            if (rec_vs > 0) pclk_since_vs++;
            if (cam_href) rec_b.push_back(cam_data);
            if (exp_q.size() == 0) done_due = 1;
          end
        end else if (done_due) begin
          done_due = 0;
          check("frame_done", frame_done, 1);
          exp_fcnt = (exp_fcnt + 1) % 65536;
          check("frame_cnt", frame_cnt, exp_fcnt);
          if (done_at < 0) done_at = pclk_since_vs;
          if (enable) push_frame(0);
          else begin
            check("idle_busy", busy, 0);
            check("idle_pclk", cam_pclk, 0);
          end
        end else begin
          check("no_done", frame_done, 0);
        end
        pclk_prev = cam_pclk;
      end
    end
  end

  task automatic start_frame(input logic [1:0] pat, input logic [15:0] solid);
    @(negedge clk);
    pattern_sel   = pat;
    solid_rgb565  = solid;
    enable        = 1'b1;
    rec_b.delete();
    rec_vs        = 0;
    pclk_since_vs = 0;
    done_at       = -1;
    push_frame(1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || done_due || busy) && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, n < 3000, 1);
  endtask

  task automatic wait_bytes(input int k, input string name);
    int n = 0;
    while (rec_b.size() < k && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, n < 1000, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pclk"}, cam_pclk, 0);
    check({tag, "_vsync"}, cam_vsync, 0);
    check({tag, "_href"}, cam_href, 0);
    check({tag, "_data"}, cam_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_fcnt"}, frame_cnt, 0);
`ifdef FRAME_CRC_EN
    check({tag, "_crc"}, frame_crc, 0);
`endif
  endtask

  task automatic check_addr_frame(input string tag);
    check({tag, "_vsync_pclks"}, rec_vs, 10);
    check({tag, "_href_bytes"}, rec_b.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_byte%0d", tag, i), (i < rec_b.size()) ? rec_b[i] : 8'hEE, A_BYTES[i]);
    check({tag, "_done_after_pclks"}, done_at, 50);
  endtask

  logic [15:0] crc_ref;

  initial begin
    int n;
    logic fb;
    crc_ref = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = crc_ref[15] ^ A_BYTES[i][b];
        crc_ref = {crc_ref[14:0], 1'b0};
        if (fb) crc_ref = crc_ref ^ 16'h1021;
      end
    end

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pclk_held", cam_pclk, 0);

    // Address-coded frame, single shot
    start_frame(2'b10, 16'h0000);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_idle("wait_frame_a");
    check_addr_frame("addr");
    check("addr_frame_cnt", frame_cnt, 1);
`ifdef FRAME_CRC_EN
    check("addr_crc", frame_crc, crc_ref);
`endif

    // Solid red
    start_frame(2'b00, 16'hF800);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_idle("wait_frame_b");
    check("solid_href_bytes", rec_b.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("solid_byte%0d", i), (i < rec_b.size()) ? rec_b[i] : 8'hEE,
            (i % 2 == 0) ? 8'hF8 : 8'h00);
    check("solid_frame_cnt", frame_cnt, 2);

    // Bars, pattern changed mid-frame to gradient, enable dropped mid-ACTIVE of frame 2
    start_frame(2'b01, 16'h0000);
    wait_bytes(4, "wait_bars_bytes");
    @(negedge clk);
    pattern_sel = 2'b11;
    wait_bytes(20, "wait_grad_bytes");
    @(negedge clk);
    enable = 1'b0;
    wait_idle("wait_frame_c");
    check("two_frames_bytes", rec_b.size(), 32);
    for (int i = 0; i < 8; i++)
      check($sformatf("bars_byte%0d", i), (i < rec_b.size()) ? rec_b[i] : 8'hEE, BAR_BYTES[i]);
    check("grad_px11_hi", (rec_b.size() > 27) ? rec_b[26] : 8'hEE, 8'h08);
    check("grad_px11_lo", (rec_b.size() > 27) ? rec_b[27] : 8'hEE, 8'h23);
    check("grad_frame_cnt", frame_cnt, 4);
    repeat (4) @(negedge clk);
    check("after_drop_busy", busy, 0);
    check("after_drop_pclk", cam_pclk, 0);

    // Asynchronous reset mid-ACTIVE, then a clean restart
    start_frame(2'b10, 16'h0000);
    n = 0;
    while (!cam_href && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("wait_href_for_reset", n < 500, 1);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    exp_q.delete();
    done_due = 0;
    exp_fcnt = 0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(2'b10, 16'h0000);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_idle("wait_frame_d");
    check_addr_frame("restart");
    check("restart_frame_cnt", frame_cnt, 1);
`ifdef FRAME_CRC_EN
    check("restart_crc", frame_crc, crc_ref);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
